// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
// - state_e         : loader FSM state encoding
// - BYTES_PER_WORD  : stream bytes per memory word (big-endian)
// - BCNT_W          : width of the per-word byte counter
// - is_loading()    : true while a load is in progress (start is ignored)
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  function automatic logic is_loading(state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Byte-to-word assembly for the program loader.
// Shifts accepted data bytes into a 32-bit register (first byte lands in
// bits 31:24), raises a registered one-cycle write strobe after the 4th byte
// and keeps a running XOR of every data byte for the trailing checksum.
// Ports:
//   clk, reset   clock, async active-high reset
//   clr          restart: clears byte counter and XOR accumulator
//   data_acc     a data byte is being accepted this cycle
//   in_data      the byte
//   word_done    comb: this acceptance completes a word
//   mem_we       registered write strobe (one cycle)
//   mem_wdata    registered completed word
//   xor_sum      XOR of all data bytes accepted since clr
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        data_acc,
  input  logic [7:0]  in_data,
  output logic        word_done,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [7:0]  xor_sum
);

  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [7:0]        xor_q, xor_d;
  logic [31:0]       next_word;

  assign next_word = {shift_q[23:0], in_data};
  assign word_done = data_acc && (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    xor_d      = xor_q;
    if (clr) begin
      byte_cnt_d = '0;
      xor_d      = '0;
    end else if (data_acc) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
      shift_d    = next_word;
      xor_d      = xor_q ^ in_data;
      // The completed word is copied out so the shift register can take the
      // next word's first byte in the same cycle the strobe is up.
      if (word_done) begin
        we_d    = 1'b1;
        wdata_d = next_word;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      xor_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      xor_q      <= xor_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign xor_sum   = xor_q;

endmodule

// File: rtl/program_loader.sv
// Program loader: takes a byte stream (LEN_HI, LEN_LO, N big-endian words,
// CSUM) and writes the words into the CPU memory write port starting at
// BASE_ADDR. The CPU is held until the image loads and its checksum (XOR of
// the data bytes only) matches.
// Ports:
//   clk, reset            clock, async active-high reset
//   start                 begin a load (honoured in IDLE/DONE/ERROR)
//   in_data/in_valid/in_ready   byte stream handshake
//   mem_we/mem_addr/mem_wdata   memory write port
//   cpu_hold              freeze CPU fetch
//   done / error          load result
module program_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  // Largest legal word count; an image of exactly this size fills memory to
  // the top word without wrapping.
  localparam logic [32:0] MAX_WORDS = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

  state_e                state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic        accept;
  logic        restart;
  logic        data_acc;
  logic        word_done;
  logic        last_word;
  logic [7:0]  xor_sum;
  logic [15:0] len_new;

  assign accept    = in_valid && in_ready;
  assign restart   = start && !is_loading(state_q);
  assign data_acc  = accept && (state_q == ST_DATA);
  assign len_new   = {len_hi_q, in_data};
  assign last_word = (word_cnt_q == len_q - 16'd1);

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clr       (restart),
    .data_acc  (data_acc),
    .in_data   (in_data),
    .word_done (word_done),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .xor_sum   (xor_sum)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_LEN_HI;
      ST_LEN_HI: if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (33'(len_new) > MAX_WORDS) state_d = ST_ERROR;
          else if (len_new == 16'd0)    state_d = ST_CSUM;
          else                          state_d = ST_DATA;
        end
      end
      ST_DATA: if (word_done && last_word) state_d = ST_CSUM;
      ST_CSUM: begin
        if (accept) state_d = (in_data == xor_sum) ? ST_DONE : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready = is_loading(state_q);
    done     = (state_q == ST_DONE);
    error    = (state_q == ST_ERROR);
    cpu_hold = (state_q != ST_DONE);
  end

  // Length capture, word counter and write address
  always_comb begin
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    if (restart) begin
      word_cnt_d = '0;
      addr_d     = ADDR_WIDTH'(BASE_ADDR);
    end else begin
      if (accept && state_q == ST_LEN_HI) len_hi_d = in_data;
      if (accept && state_q == ST_LEN_LO) len_d    = len_new;
      if (word_done) word_cnt_d = word_cnt_q + 16'd1;
      // Advance once the strobe for the current word has gone out; the next
      // word needs at least three more bytes, so this never races a write.
      if (mem_we) addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= ADDR_WIDTH'(BASE_ADDR);
    end else begin
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
    end
  end

  assign mem_addr = addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (ADDR_WIDTH=12, BASE_ADDR=0).
// The checksum covers data bytes only:
//   20^08^00^05^00^08^40^20 = 0x45 (good), 0x48 (bad).
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int cmp_cnt = 0;
  int err_cnt = 0;

  program_loader #(.ADDR_WIDTH(12), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge
  int          wr_total = 0;
  logic [11:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_total < 64) begin
        wr_addr[wr_total] = mem_addr;
        wr_data[wr_total] = mem_wdata;
      end
      wr_total = wr_total + 1;
    end
  end

  logic [7:0] img [0:9] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                            8'h00, 8'h08, 8'h40, 8'h20};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) chk("rdy_timeout", {31'd0, in_ready}, 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic exp_done);
    @(negedge clk);
    chk({tag, "_done"},  {31'd0, done},     {31'd0, exp_done});
    chk({tag, "_error"}, {31'd0, error},    {31'd0, !exp_done});
    chk({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, !exp_done});
    chk({tag, "_rdy"},   {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_two_writes(input string tag, input int base);
    chk({tag, "_nwr"}, 32'(wr_total - base), 32'd2);
    chk({tag, "_a0"},  {20'd0, wr_addr[base]},     32'h0);
    chk({tag, "_d0"},  wr_data[base],              32'h20080005);
    chk({tag, "_a1"},  {20'd0, wr_addr[base + 1]}, 32'h1);
    chk({tag, "_d1"},  wr_data[base + 1],          32'h00084020);
  endtask

  initial begin
    int base;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_rdy",  {31'd0, in_ready}, 32'd0);
      chk("idle_hold", {31'd0, cpu_hold}, 32'd1);
      chk("idle_done", {31'd0, done},     32'd0);
      chk("idle_err",  {31'd0, error},    32'd0);
    end
    chk("idle_addr",  {20'd0, mem_addr}, 32'd0);
    chk("idle_wdata", mem_wdata,         32'd0);
    chk("idle_nwr",   32'(wr_total),     32'd0);

    // Good image, back-to-back
    base = wr_total;
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(img[i], 0);
    send_byte(8'h45, 0);
    check_result("good", 1'b1);
    check_two_writes("good", base);

    // Restart from DONE: flags clear on the start edge
    base = wr_total;
    pulse_start();
    @(negedge clk);
    chk("restart_done", {31'd0, done},     32'd0);
    chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
    chk("restart_rdy",  {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) send_byte(img[i], 0);
    send_byte(8'h48, 0);
    check_result("badcs", 1'b0);
    check_two_writes("badcs", base);

    // Length overflow: 0x1001 > 4096
    base = wr_total;
    pulse_start();
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    check_result("ovf", 1'b0);
    repeat (5) @(negedge clk);
    chk("ovf_nwr", 32'(wr_total - base), 32'd0);

    // Exactly 4096 words is legal: enters DATA
    pulse_start();
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    chk("max_err", {31'd0, error},    32'd0);
    chk("max_rdy", {31'd0, in_ready}, 32'd1);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_rdy",  {31'd0, in_ready}, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    #1 reset = 1'b0;

    // Empty image: checksum 0
    base = wr_total;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_result("empty", 1'b1);
    chk("empty_nwr", 32'(wr_total - base), 32'd0);

    // Gapped stream with a stray start mid-load
    base = wr_total;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(img[i], $urandom_range(0, 2));
      if (i == 4) pulse_start();
    end
    send_byte(8'h45, 1);
    check_result("gap", 1'b1);
    check_two_writes("gap", base);

    // Reset after 6 data bytes, then a clean load
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(img[i], 0);
    reset = 1'b1;
    base = wr_total;
    repeat (2) @(negedge clk);
    chk("abort_we",   {31'd0, mem_we},   32'd0);
    chk("abort_hold", {31'd0, cpu_hold}, 32'd1);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_nwr", 32'(wr_total - base), 32'd0);
    base = wr_total;
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(img[i], 0);
    send_byte(8'h45, 0);
    check_result("fresh", 1'b1);
    check_two_writes("fresh", base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
